coproc_port_ctrl: RTL

Sequences the FPGA coprocessor from the PIC32 parallel-port side. Receives a byte-serial command frame (command byte, operand A, operand B) on an 8-bit port with a strobe, then launches the coprocessor datapath with a one-cycle start pulse. Waits for its done, then returns the result to the MCU one nibble at a time over a 4-bit output, paced by a read strobe. Sits between the port input/output buffers and the coprocessor datapath, in the multiplied-clock domain.

---
 rtl/coproc_port_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/coproc_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coproc_port_ctrl
// Brief    : PIC32 parallel-port sequencer for the coprocessor datapath.
//            Define COP_TIMEOUT_EN to abort a BUSY phase after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module coproc_port_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       mcu_data,
  input  logic             mcu_strobe,
  input  logic             mcu_read,
  output logic [3:0]       mcu_nibble,
  output logic             mcu_ready,
  output logic             mcu_busy,
  output logic             mcu_error,
  output logic             cop_start,
  output logic [1:0]       cop_op,
  output logic [WIDTH-1:0] cop_a,
  output logic [WIDTH-1:0] cop_b,
  input  logic             cop_done,
  input  logic [WIDTH-1:0] cop_result
);

  localparam int c_bytes   = WIDTH / 8;
  localparam int c_nibbles = WIDTH / 4;
  localparam int c_cnt_w   = $clog2(2 * c_bytes);
  localparam int c_nib_w   = $clog2(c_nibbles);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_BUSY   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2:0]           r_strobe_sync;
  logic [2:0]           r_read_sync;
  logic [7:0]           r_data_s1;
  logic [7:0]           r_data_s2;
  logic                 w_strobe_edge;
  logic                 w_read_edge;
  logic [c_cnt_w-1:0]   r_byte_cnt;
  logic [c_nib_w-1:0]   r_nib_cnt;
  logic [c_nib_w-1:0]   w_nib_inc;
  logic                 w_last_byte;
  logic                 w_last_nib;
  logic                 w_timeout;
  logic [3:0]           w_next_nib;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [1:0]           r_op;
  logic [3:0]           r_nibble;
  logic                 r_start;
  logic                 r_error;

  // Data is only ever sampled at s2, in step with the strobe edge, so it needs
  // no third stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_strobe_sync <= 3'b000;
      r_read_sync   <= 3'b000;
      r_data_s1     <= 8'h00;
      r_data_s2     <= 8'h00;
    end else begin
      r_strobe_sync <= {r_strobe_sync[1:0], mcu_strobe};
      r_read_sync   <= {r_read_sync[1:0], mcu_read};
      r_data_s1     <= mcu_data;
      r_data_s2     <= r_data_s1;
    end
  end

  assign w_strobe_edge = r_strobe_sync[1] & ~r_strobe_sync[2];
  assign w_read_edge   = r_read_sync[1] & ~r_read_sync[2];
  assign w_last_byte   = (r_byte_cnt == c_cnt_w'(2 * c_bytes - 1));
  assign w_last_nib    = (r_nib_cnt == c_nib_w'(c_nibbles - 1));
  assign w_nib_inc     = r_nib_cnt + 1'b1;

`ifdef COP_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  logic [c_to_w-1:0] r_to_cnt;

  always_ff @(posedge clock) begin
    if (reset || r_state != S_BUSY) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_BUSY) && !cop_done
                     && (r_to_cnt == c_to_w'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_strobe_edge) w_state_next = S_LOAD;
      S_LOAD:   if (w_strobe_edge && w_last_byte) w_state_next = S_BUSY;
      S_BUSY:   if (cop_done || w_timeout) w_state_next = S_RESULT;
      S_RESULT: begin
        // A strobe edge starts a new command and masks a coincident read.
        if (w_strobe_edge) begin
          w_state_next = S_LOAD;
        end else if (w_read_edge && w_last_nib) begin
          w_state_next = S_IDLE;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_nib = 4'h0;
    for (int n = 0; n < c_nibbles; n++) begin
      if (w_nib_inc == c_nib_w'(n)) w_next_nib = r_result[4*n +: 4];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_nib_cnt  <= '0;
      r_result   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 2'b00;
      r_nibble   <= 4'h0;
      r_start    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE, S_RESULT: begin
          if (w_strobe_edge) begin
            r_op       <= r_data_s2[1:0];
            r_byte_cnt <= '0;
            r_error    <= 1'b0;
          end else if (r_state == S_RESULT && w_read_edge) begin
            r_nib_cnt <= w_nib_inc;
            if (!w_last_nib) r_nibble <= w_next_nib;
          end
        end
        S_LOAD: begin
          if (w_strobe_edge) begin
            // Little-endian: first half of the operand bytes fill A, the rest B.
            for (int k = 0; k < c_bytes; k++) begin
              if (r_byte_cnt == c_cnt_w'(k))           r_a[8*k +: 8] <= r_data_s2;
              if (r_byte_cnt == c_cnt_w'(k + c_bytes)) r_b[8*k +: 8] <= r_data_s2;
            end
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (w_last_byte) r_start <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cop_done) begin
            r_result  <= cop_result;
            r_nib_cnt <= '0;
            r_nibble  <= cop_result[3:0];
          end else if (w_timeout) begin
            r_result  <= '1;
            r_nib_cnt <= '0;
            r_nibble  <= 4'hF;
            r_error   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mcu_nibble = r_nibble;
  assign mcu_ready  = (r_state == S_RESULT);
  assign mcu_busy   = (r_state == S_LOAD) || (r_state == S_BUSY);
  assign mcu_error  = r_error;
  assign cop_start  = r_start;
  assign cop_op     = r_op;
  assign cop_a      = r_a;
  assign cop_b      = r_b;

endmodule
`default_nettype wire
